// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce stimulus blocks.
// Holds the burst FSM state encoding and the 16-bit Galois LFSR definition.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Galois LFSR with a configurable non-zero seed.
// Reusable pseudo-random source for lab stimulus blocks.
module bounce_lfsr
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  // Advance every cycle; reset reloads the seed so sequences are repeatable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/sw_bounce_gen.sv
// Switch-bounce emulator: turns a clean level into a noisy switch line.
// Each level change starts a pseudo-random burst of toggles with random
// hold times, then sw settles at the target and done pulses once.
// Optional build macro GLITCH_INJECT_EN adds rare single-cycle glitches
// on sw while idle.
module sw_bounce_gen
  import bounce_pkg::*;
#(
  parameter int          HOLD_W      = 4,
  parameter int          MAX_BOUNCES = 7,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl_in,
  output logic sw,
  output logic busy,
  output logic done
);

  // Remaining-toggle counter width; at least one bit even for MAX_BOUNCES=0.
  localparam int RW = (MAX_BOUNCES < 2) ? 1 : $clog2(MAX_BOUNCES + 1);
  // Hold counter needs one extra bit so 2^HOLD_W itself is representable.
  localparam int HW = HOLD_W + 1;
  localparam logic [RW-1:0] REM_MAX = RW'(MAX_BOUNCES);

  logic [LFSR_W-1:0] lfsr;
  state_t            state;
  logic              sw_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              tgt;
  logic [HW-1:0]     hold;
  logic [RW-1:0]     rem;

  logic [RW-1:0]     rem_load;
  logic [HW-1:0]     hold_load;
  logic              retarget;
  logic              lfsr_unused;

  bounce_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only some LFSR bits feed the burst; the rest are intentionally dropped.
  assign lfsr_unused = ^lfsr;

  // Burst parameters drawn from the current LFSR value, plus retarget detect.
  always_comb begin
    rem_load  = (lfsr[RW-1:0] > REM_MAX) ? REM_MAX : lfsr[RW-1:0];
    hold_load = HW'(lfsr[LFSR_W-1 -: HOLD_W]) + HW'(1);
    retarget  = (lvl_in != tgt);
  end

  // Burst FSM: load on a new target, count hold periods, toggle, then settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sw_reg   <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      tgt      <= 1'b0;
      hold     <= '0;
      rem      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (retarget) begin
            rem      <= rem_load;
            hold     <= hold_load;
            sw_reg   <= lvl_in;
            tgt      <= lvl_in;
            busy_reg <= 1'b1;
            state    <= BOUNCE;
          end
        end
        BOUNCE: begin
          if (retarget) begin
            // A new target aborts the burst silently and restarts it.
            rem    <= rem_load;
            hold   <= hold_load;
            sw_reg <= lvl_in;
            tgt    <= lvl_in;
          end else if (hold == HW'(1)) begin
            if (rem != '0) begin
              sw_reg <= ~sw_reg;
              rem    <= rem - RW'(1);
              hold   <= hold_load;
            end else begin
              // Final segment over: force the target level and report it.
              sw_reg   <= tgt;
              done_reg <= 1'b1;
              busy_reg <= 1'b0;
              hold     <= '0;
              state    <= IDLE;
            end
          end else begin
            hold <= hold - HW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

`ifdef GLITCH_INJECT_EN
  logic glitch_reg;

  // Rare one-cycle glitch while idle; never repeats on back-to-back cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_reg <= 1'b0;
    end else begin
      glitch_reg <= !glitch_reg && (state == IDLE) && !retarget &&
                    (lfsr[15:12] == 4'hF) && (lfsr[3:0] == 4'h0);
    end
  end

  assign sw = sw_reg ^ glitch_reg;
`else
  assign sw = sw_reg;
`endif

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Self-checking bench for sw_bounce_gen: a segment-plan reference model
// predicts sw/busy/done every cycle for the default instance, while directed
// steps check reset, clean edges, random bursts, aborts and mid-burst reset.
module tb_sw_bounce_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MAXB = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lvl_in = 1'b1;
  logic lvl_in0 = 1'b0;
  logic sw, busy, done;
  logic sw0, busy0, done0;

  int checks_total = 0;
  int checks_passed = 0;
  logic chk_en = 1'b0;

  sw_bounce_gen u_dut (
    .clk    (clk),
    .rst    (rst),
    .lvl_in (lvl_in),
    .sw     (sw),
    .busy   (busy),
    .done   (done)
  );

  sw_bounce_gen #(
    .HOLD_W      (2),
    .MAX_BOUNCES (0),
    .SEED        (SEED)
  ) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .lvl_in (lvl_in0),
    .sw     (sw0),
    .busy   (busy0),
    .done   (done0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_total++;
    assert (obs === exp_v) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic sw;
    logic busy;
    logic done;
  } exp_t;

  exp_t       plan[$];
  exp_t       exp_now = '0;
  logic [15:0] m_lfsr = SEED;
  logic       m_tgt = 1'b0;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Expand a burst into per-cycle expected outputs: segments of random
  // length alternating level, then a single settled cycle with done.
  task automatic build_plan(input logic [15:0] start, input logic level);
    logic [15:0] l;
    int r, h;
    logic v;
    plan.delete();
    l = start;
    r = int'(start[2:0]);
    if (r > MAXB) r = MAXB;
    h = int'(start[15:12]) + 1;
    v = level;
    forever begin
      for (int i = 0; i < h; i++) begin
        plan.push_back('{sw: v, busy: 1'b1, done: 1'b0});
        l = ref_step(l);
      end
      if (r == 0) break;
      v = ~v;
      r--;
      h = int'(l[15:12]) + 1;
    end
    plan.push_back('{sw: level, busy: 1'b0, done: 1'b1});
  endtask

  // Model advance: retarget rebuilds the plan, then one entry is consumed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = SEED;
      m_tgt = 1'b0;
      plan.delete();
      exp_now = '0;
    end else begin
      if (lvl_in != m_tgt) begin
        m_tgt = lvl_in;
        build_plan(m_lfsr, lvl_in);
      end
      if (plan.size() > 0) exp_now = plan.pop_front();
      else exp_now = '{sw: m_tgt, busy: 1'b0, done: 1'b0};
      m_lfsr = ref_step(m_lfsr);
    end
  end

  // Cycle-by-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sw", {31'd0, sw}, {31'd0, exp_now.sw});
      check("model_busy", {31'd0, busy}, {31'd0, exp_now.busy});
      check("model_done", {31'd0, done}, {31'd0, exp_now.done});
    end
  end

  // ---------------- directed stimulus ----------------
  logic trace_a[150];
  logic trace_b[150];

  initial begin
    int edges, busy_cyc, dones, mism;
    logic prev, sw_at_done, busy_all5;

    // Reset with lvl_in=1: everything stays low while held.
    #1 rst = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_sw", {31'd0, sw}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      trace_a[k] = sw;
      if (k == 0) begin
        check("post_rst_sw", {31'd0, sw}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd1);
      end
    end

    // Clean-edge instance: single edge, short busy, one done.
    lvl_in0 = 1'b1;
    prev = sw0;
    edges = 0; busy_cyc = 0; dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) check("clean_sw_1cyc", {31'd0, sw0}, 32'd1);
      if (sw0 != prev) edges++;
      prev = sw0;
      if (busy0) busy_cyc++;
      if (done0) dones++;
    end
    check("clean_edges", edges, 1);
    check("clean_busy_range", {31'd0, (busy_cyc >= 1 && busy_cyc <= 4)}, 32'd1);
    check("clean_done_cnt", dones, 1);
    check("clean_sw_final", {31'd0, sw0}, 32'd1);

    // Random-phase level changes on the default instance.
    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      prev = sw;
      lvl_in = ~lvl_in;
      edges = 0; busy_cyc = 0; dones = 0; sw_at_done = 1'bx;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (sw != prev) edges++;
        prev = sw;
        if (busy) busy_cyc++;
        if (done) begin
          dones++;
          sw_at_done = sw;
        end
      end
      check("burst_edges_le9", {31'd0, (edges <= MAXB + 2)}, 32'd1);
      check("burst_busy_le128", {31'd0, (busy_cyc <= 128)}, 32'd1);
      check("burst_done_cnt", dones, 1);
      check("burst_sw_at_done", {31'd0, sw_at_done}, {31'd0, lvl_in});
    end

    // Retarget 5 cycles into a burst.
    lvl_in = ~lvl_in;
    busy_all5 = 1'b1; dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!busy) busy_all5 = 1'b0;
      if (done) dones++;
    end
    if (busy_all5) check("abort_no_early_done", dones, 0);
    lvl_in = ~lvl_in;
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_done_cnt", dones, 1);
    check("abort_sw_final", {31'd0, sw}, {31'd0, lvl_in});
    check("abort_busy_final", {31'd0, busy}, 32'd0);

    // Reset mid-burst, then replay the first post-reset burst.
    lvl_in = ~lvl_in;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sw", {31'd0, sw}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    lvl_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      trace_b[k] = sw;
    end
    mism = 0;
    for (int k = 0; k < 150; k++) begin
      if (trace_a[k] !== trace_b[k]) mism++;
    end
    check("replay_trace_mism", mism, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
